// File: rtl/synchronous_fifo_pkg.sv
// synchronous_fifo_pkg: default sizing constants shared by the FIFO top and
// its storage sub-module.
package synchronous_fifo_pkg;

  localparam int SF_DATA_WIDTH = 8;
  localparam int SF_BUF_WIDTH  = 3;
  localparam int SF_DEPTH      = 1 << SF_BUF_WIDTH;

  // Number of entries addressable with an address of the given width.
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/synchronous_fifo_mem.sv
// synchronous_fifo_mem: DEPTH x DATA_WIDTH storage with a synchronous write
// port and a registered read port. The array itself is never reset; only the
// read data register is cleared so the FIFO output starts at zero.
module synchronous_fifo_mem
  import synchronous_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SF_DATA_WIDTH,
  parameter int ADDR_WIDTH = SF_BUF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port: store the incoming word when the controller accepts a write.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: register the addressed word on an accepted read, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/synchronous_fifo.sv
// synchronous_fifo: single-clock FIFO with occupancy counter and registered
// read data. Pointer and counter control live here; storage is in
// synchronous_fifo_mem.
// Optional feature macro: SYNCHRONOUS_FIFO_ERR_FLAGS_EN adds wr_err/rd_err,
// one-cycle pulses flagging a write rejected while full or a read rejected
// while empty.
module synchronous_fifo
  import synchronous_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SF_DATA_WIDTH,
  parameter int BUF_WIDTH  = SF_BUF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic [BUF_WIDTH:0]    fifo_counter
`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
  ,
  output logic                  wr_err,
  output logic                  rd_err
`endif
);

  // Occupancy value meaning "full" (DEPTH), sized to the counter width.
  localparam logic [BUF_WIDTH:0] L_DEPTH = {1'b1, {BUF_WIDTH{1'b0}}};

  logic [BUF_WIDTH-1:0] r_wr_ptr;
  logic [BUF_WIDTH-1:0] r_rd_ptr;
  logic [BUF_WIDTH:0]   r_count;
  logic                 w_wr_acc;
  logic                 w_rd_acc;

  // Handshake: wr_en acts as a valid with !buf_full as its ready, and rd_en
  // as a request with !buf_empty as its ready. A request is accepted exactly
  // on a clk edge where both are high (and rst is low); a request not
  // accepted is dropped, never queued. Full and empty are mutually exclusive,
  // so a simultaneous write and read never target the same entry.
  assign w_wr_acc = wr_en && !buf_full;
  assign w_rd_acc = rd_en && !buf_empty;

  // Status flags follow the counter combinationally.
  assign buf_empty    = (r_count == '0);
  assign buf_full     = (r_count == L_DEPTH);
  assign fifo_counter = r_count;

  // Write pointer: advances on each accepted write, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer: advances on each accepted read, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_rd_acc) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: +1 on a lone write, -1 on a lone read, unchanged on both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      r_count <= r_count + 1'b1;
    end else if (w_rd_acc && !w_wr_acc) begin
      r_count <= r_count - 1'b1;
    end
  end

`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
  logic r_wr_err;
  logic r_rd_err;

  // Error pulses: high for the single cycle after a rejected request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_err <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en && buf_full;
      r_rd_err <= rd_en && buf_empty;
    end
  end

  assign wr_err = r_wr_err;
  assign rd_err = r_rd_err;
`endif

  synchronous_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (BUF_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (buf_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (buf_out)
  );

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb_synchronous_fifo: directed vector table plus randomized traffic for
// synchronous_fifo, checked against a queue-based reference model.
// Build with SYNCHRONOUS_FIFO_ERR_FLAGS_EN defined to also check wr_err/rd_err.
module tb_synchronous_fifo;

  localparam int DW    = 8;
  localparam int BW    = 3;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] buf_in;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] buf_out;
  logic          buf_empty;
  logic          buf_full;
  logic [BW:0]   fifo_counter;
`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
  logic          wr_err;
  logic          rd_err;
`endif

  always #5 clk = ~clk;

  synchronous_fifo #(
    .DATA_WIDTH (DW),
    .BUF_WIDTH  (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buf_in       (buf_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter)
`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
    ,
    .wr_err       (wr_err),
    .rd_err       (rd_err)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_out  = '0;
  logic          m_werr = 1'b0;
  logic          m_rerr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural FIFO: a queue with capacity DEPTH; read data is the popped head.
  task automatic model_step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    if (r) begin
      exp_q.delete();
      m_out  = '0;
      m_werr = 1'b0;
      m_rerr = 1'b0;
    end else begin
      bit wok = w && (exp_q.size() < DEPTH);
      bit rok = rd && (exp_q.size() > 0);
      m_werr = w && !wok;
      m_rerr = rd && !rok;
      if (rok) m_out = exp_q.pop_front();
      if (wok) exp_q.push_back(d);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d,
                       input string tag);
    rst    = r;
    wr_en  = w;
    rd_en  = rd;
    buf_in = d;
    model_step(r, w, rd, d);
    @(posedge clk);
    #1;
    check({tag, " buf_out"},   buf_out,      m_out);
    check({tag, " counter"},   fifo_counter, exp_q.size());
    check({tag, " buf_empty"}, buf_empty,    exp_q.size() == 0);
    check({tag, " buf_full"},  buf_full,     exp_q.size() == DEPTH);
`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
    check({tag, " wr_err"},    wr_err,       m_werr);
    check({tag, " rd_err"},    rd_err,       m_rerr);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          r;
    logic          w;
    logic          rd;
    logic [DW-1:0] d;
    logic [DW-1:0] e_out;
    int            e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic rd, input int d,
                     input int e_out, input int e_cnt);
    vec_t v;
    v.r     = r;
    v.w     = w;
    v.rd    = rd;
    v.d     = DW'(d);
    v.e_out = DW'(e_out);
    v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;

    // reset for two edges, then idle
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // push 1, then push 2 with a pop
    add(0, 1, 0, 1, 0, 1);
    add(0, 1, 1, 2, 1, 1);
    // push 10..70 -> full
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 10 * i, 1, 1 + i);
    // push 80 while full -> dropped
    add(0, 1, 0, 80, 1, 8);
    // drain: 2,10..70
    add(0, 0, 1, 0, 2, 7);
    for (int i = 1; i <= 7; i++) add(0, 0, 1, 0, 10 * i, 7 - i);
    // ninth pop on empty holds 70
    add(0, 0, 1, 0, 70, 0);
    // fill with 90..97
    for (int i = 0; i < 8; i++) add(0, 1, 0, 90 + i, 70, i + 1);
    // full with push 140 + pop: only the read happens
    add(0, 1, 1, 140, 90, 7);
    for (int i = 1; i <= 7; i++) add(0, 0, 1, 0, 90 + i, 7 - i);
    // extra pop: still 97, so 140 never entered
    add(0, 0, 1, 0, 97, 0);
    // empty with push 55 + pop: only the write happens
    add(0, 1, 1, 55, 97, 1);
    add(0, 0, 1, 0, 55, 0);
    // reset mid-operation discards entries and overrides wr/rd
    add(0, 1, 0, 3, 55, 1);
    add(0, 1, 0, 4, 55, 2);
    add(1, 1, 1, 9, 0, 0);
    add(0, 0, 1, 0, 0, 0);

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      cycle(vecs[k].r, vecs[k].w, vecs[k].rd, vecs[k].d, tag);
      check({tag, " tbl_out"}, buf_out, vecs[k].e_out);
      check({tag, " tbl_cnt"}, fifo_counter, vecs[k].e_cnt);
    end

    // ---------------- pointer wrap: 12 pushes interleaved with 12 pops ----------------
    cycle(1, 0, 0, 0, "wrap_rst");
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, DW'(200 + i), "wrap_fill");
    for (int i = 3; i < 12; i++) cycle(0, 1, 1, DW'(200 + i), "wrap_both");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "wrap_drain");
    check("wrap last_out", buf_out, 211);
    check("wrap empty", buf_empty, 1);

    // ---------------- randomized traffic ----------------
    for (int ph = 0; ph < 3; ph++) begin
      int wp;
      wp = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
      for (int n = 0; n < 150; n++) begin
        logic r, w, rd;
        r  = ($urandom_range(0, 99) == 0);
        w  = ($urandom_range(0, 99) < wp);
        rd = ($urandom_range(0, 99) < (100 - wp));
        cycle(r, w, rd, DW'($urandom), $sformatf("rnd%0d_%0d", ph, n));
        if (fifo_counter > DEPTH) check("rnd counter_bound", fifo_counter, DEPTH);
      end
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
